// File: rtl/alu_share_arb.sv
// Shares one external combinational 32-bit ALU between two requesters: round-robin
// arbitration into a registered issue stage, results parked in a per-requester buffer.
module alu_share_arb (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_src0,
   input  logic [31:0] req0_src1,
   input  logic [4:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_src0,
   input  logic [31:0] req1_src1,
   input  logic [4:0]  req1_op,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_res,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_res,
   output logic [31:0] alu_src0,
   output logic [31:0] alu_src1,
   output logic [4:0]  alu_op,
   input  logic [31:0] alu_res
);
   localparam int NUM_REQ = 2;

   typedef struct packed {
      logic [31:0] src0;
      logic [31:0] src1;
      logic [4:0]  op;
   } alu_req_t;

   alu_req_t [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            resp_ready;
   logic [NUM_REQ-1:0]            resp_valid;
   logic [NUM_REQ-1:0][31:0]      resp_res;
   logic [NUM_REQ-1:0]            elig;
   logic [NUM_REQ-1:0]            win;
   logic [NUM_REQ-1:0]            wb;

   logic     last_gnt;
   logic     s1_valid;
   logic     s1_owner;
   alu_req_t s1_req;

   assign req_valid  = {req1_valid, req0_valid};
   assign resp_ready = {resp1_ready, resp0_ready};
   assign req[0]     = {req0_src0, req0_src1, req0_op};
   assign req[1]     = {req1_src0, req1_src1, req1_op};

   // Tie goes to whoever did not win last; ready is held low while in reset.
   assign win[0] = rstn && elig[0] && (!elig[1] ||  last_gnt);
   assign win[1] = rstn && elig[1] && (!elig[0] || !last_gnt);

   assign req0_ready = win[0];
   assign req1_ready = win[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_gnt <= 1'b1;
         s1_valid <= 1'b0;
         s1_owner <= 1'b0;
         s1_req   <= '0;
      end else begin
         s1_valid <= |win;
         if (|win) begin
            s1_owner <= win[1];
            last_gnt <= win[1];
            s1_req   <= win[1] ? req[1] : req[0];
         end
      end
   end

   assign alu_src0 = s1_req.src0;
   assign alu_src1 = s1_req.src1;
   assign alu_op   = s1_req.op;

   assign wb = !s1_valid ? 2'b00 : (s1_owner ? 2'b10 : 2'b01);

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
         logic        busy;
         logic        rv;
         logic [31:0] rres;
         logic        pop;

         assign pop     = rv && resp_ready[i];
         // Popping the old result frees the slot for a new accept in the same cycle.
         assign elig[i] = req_valid[i] && (!busy || pop);

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               busy <= 1'b0;
               rv   <= 1'b0;
               rres <= '0;
            end else begin
               if (win[i])
                  busy <= 1'b1;
               else if (pop)
                  busy <= 1'b0;
               if (wb[i]) begin
                  rv   <= 1'b1;
                  rres <= alu_res;
               end else if (pop) begin
                  rv   <= 1'b0;
               end
            end
         end

         assign resp_valid[i] = rv;
         assign resp_res[i]   = rres;
      end
   endgenerate

   assign resp0_valid = resp_valid[0];
   assign resp1_valid = resp_valid[1];
   assign resp0_res   = resp_res[0];
   assign resp1_res   = resp_res[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU on the ALU port, directed scenarios and a
// randomized run against a transaction-level model of outstanding operations.
module tb_alu_share_arb;
   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_src0, req0_src1, req1_src0, req1_src1;
   logic [4:0]  req0_op, req1_op;
   logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
   logic [31:0] resp0_res, resp1_res;
   logic [31:0] alu_src0, alu_src1, alu_res;
   logic [4:0]  alu_op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'b00000: return a + b;
         5'b00010: return a - b;
         5'b00100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'b00101: return (a < b) ? 32'd1 : 32'd0;
         5'b01001: return a & b;
         5'b01010: return a | b;
         5'b01011: return a ^ b;
         5'b01110: return a << b[4:0];
         5'b01111: return a >> b[4:0];
         5'b10000: return $signed(a) >>> b[4:0];
         5'b10001: return a;
         5'b10010: return b;
         default:  return 32'd0;
      endcase
   endfunction

   assign alu_res = alu_f(alu_op, alu_src0, alu_src1);

   alu_share_arb dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_src0(req0_src0), .req0_src1(req0_src1), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_src0(req1_src0), .req1_src1(req1_src1), .req1_op(req1_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_res(resp0_res),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_res(resp1_res),
      .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op), .alu_res(alu_res)
   );

   // Model: per requester, one outstanding op with its result and the cycle it becomes visible.
   bit          m_out [2];
   logic [31:0] m_res [2];
   int          m_due [2];
   bit          m_last;
   logic [31:0] m_a0, m_a1;
   logic [4:0]  m_aop;
   int          cyc = 0;
   logic [1:0]  e_rdy, e_rv;

   task automatic model_reset();
      m_out[0] = 0; m_out[1] = 0;
      m_last = 1'b1;
      m_a0 = '0; m_a1 = '0; m_aop = '0;
   endtask

   task automatic predict();
      logic [1:0] v, rr, el;
      v  = {req1_valid, req0_valid};
      rr = {resp1_ready, resp0_ready};
      for (int i = 0; i < 2; i++) begin
         e_rv[i] = m_out[i] && (cyc >= m_due[i]);
         el[i]   = v[i] && (!m_out[i] || (e_rv[i] && rr[i]));
      end
      e_rdy[0] = el[0] && (!el[1] || m_last == 1'b1);
      e_rdy[1] = el[1] && (!el[0] || m_last == 1'b0);
   endtask

   task automatic advance();
      if (e_rv[0] && resp0_ready) m_out[0] = 0;
      if (e_rv[1] && resp1_ready) m_out[1] = 0;
      if (e_rdy[0]) begin
         m_out[0] = 1; m_res[0] = alu_f(req0_op, req0_src0, req0_src1); m_due[0] = cyc + 2;
         m_last = 1'b0; m_a0 = req0_src0; m_a1 = req0_src1; m_aop = req0_op;
      end else if (e_rdy[1]) begin
         m_out[1] = 1; m_res[1] = alu_f(req1_op, req1_src0, req1_src1); m_due[1] = cyc + 2;
         m_last = 1'b1; m_a0 = req1_src0; m_a1 = req1_src1; m_aop = req1_op;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
      predict();
   endtask

   task automatic set_req0(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_op = op; req0_src0 = a; req0_src1 = b;
   endtask

   task automatic set_req1(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_op = op; req1_src0 = a; req1_src1 = b;
   endtask

   task automatic idle();
      req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
   endtask

   task automatic drain();
      idle();
      resp0_ready = 1; resp1_ready = 1;
      repeat (4) begin settle(); advance(); end
      idle();
   endtask

   task automatic do_reset();
      #2 rstn = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle();
      set_req0(1, 5'b00000, 32'd1, 32'd2);
      set_req1(1, 5'b00010, 32'd9, 32'd3);
      model_reset();
      @(negedge clk); #1;
      checks++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl got=%b exp=0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
      end
      @(negedge clk);
      rstn = 1'b1;
      // load s1 with req1 while resp0 is pending, then reset mid-cycle
      set_req1(0, 5'b00010, 32'd9, 32'd3);
      settle(); advance();
      set_req0(0, 5'b00000, 32'd1, 32'd2);
      set_req1(1, 5'b00010, 32'd9, 32'd3);
      settle(); advance();
      set_req0(1, 5'b00000, 32'd1, 32'd2);
      settle();
      checks++;
      if (resp0_valid !== 1'b1 || alu_op !== 5'b00010) begin
         errors++; $display("FAIL midstream_load got=%b/%b exp=1/00010", resp0_valid, alu_op);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
         errors++; $display("FAIL async_reset_ctl got=%b exp=0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
      end
      checks++;
      if ({resp0_res, resp1_res} !== 64'd0) begin
         errors++; $display("FAIL async_reset_res got=%h exp=0", {resp0_res, resp1_res});
      end
      checks++;
      if ({alu_src0, alu_src1, alu_op} !== 69'd0) begin
         errors++; $display("FAIL async_reset_alu got=%h exp=0", {alu_src0, alu_src1, alu_op});
      end
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      settle();
      checks++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         errors++; $display("FAIL first_tie got=%b exp=01", {req1_ready, req0_ready});
      end
      advance();
      drain();
   endtask

   task automatic test_single_op();
      set_req0(1, 5'b00000, 32'h7FFFFFFF, 32'h00000001);
      settle();
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", req0_ready); end
      advance();
      req0_valid = 0;
      settle();
      checks++;
      if (alu_op !== 5'b00000 || alu_src0 !== 32'h7FFFFFFF || resp0_valid !== 1'b0) begin
         errors++; $display("FAIL single_issue got=%b/%h/%b exp=00000/7fffffff/0", alu_op, alu_src0, resp0_valid);
      end
      advance();
      resp0_ready = 1;
      settle();
      checks++;
      if (resp0_valid !== 1'b1 || resp0_res !== 32'h80000000) begin
         errors++; $display("FAIL single_result got=%b/%h exp=1/80000000", resp0_valid, resp0_res);
      end
      advance();
      resp0_ready = 0;
      settle();
      checks++;
      if (resp0_valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", resp0_valid); end
      advance();
      drain();
   endtask

   task automatic test_tie();
      do_reset();
      set_req0(1, 5'b00010, 32'd5, 32'd7);
      set_req1(1, 5'b10000, 32'h80000000, 32'd4);
      resp0_ready = 1; resp1_ready = 1;
      for (int k = 0; k < 8; k++) begin
         settle();
         checks++;
         if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL tie_grant k=%0d got=%b", k, {req1_ready, req0_ready});
         end
         checks++;
         if (resp0_valid !== (k >= 2 && k % 2 == 0) || resp1_valid !== (k >= 3 && k % 2 == 1)) begin
            errors++; $display("FAIL tie_valid k=%0d got=%b%b", k, resp1_valid, resp0_valid);
         end
         if (resp0_valid === 1'b1) begin
            checks++;
            if (resp0_res !== 32'hFFFFFFFE) begin errors++; $display("FAIL tie_res0 got=%h exp=fffffffe", resp0_res); end
         end
         if (resp1_valid === 1'b1) begin
            checks++;
            if (resp1_res !== 32'hF8000000) begin errors++; $display("FAIL tie_res1 got=%h exp=f8000000", resp1_res); end
         end
         advance();
      end
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      set_req0(1, 5'b00101, 32'd1, 32'hFFFFFFFF);
      set_req1(1, 5'b01011, 32'hF0F0F0F0, 32'h0FF00FF0);
      resp0_ready = 1; resp1_ready = 0;
      for (int k = 0; k < 12; k++) begin
         settle();
         checks++;
         if (req0_ready !== (k % 2 == 0) || req1_ready !== (k == 1)) begin
            errors++; $display("FAIL bp_grant k=%0d got=%b%b", k, req1_ready, req0_ready);
         end
         checks++;
         if (resp1_valid !== (k >= 3) || (k >= 3 && resp1_res !== 32'hFF00FF00)) begin
            errors++; $display("FAIL bp_hold k=%0d got=%b/%h exp=%b/ff00ff00", k, resp1_valid, resp1_res, k >= 3);
         end
         checks++;
         if (resp0_valid !== (k >= 2 && k % 2 == 0) || (resp0_valid === 1'b1 && resp0_res !== 32'd1)) begin
            errors++; $display("FAIL bp_req0 k=%0d got=%b/%h", k, resp0_valid, resp0_res);
         end
         advance();
      end
      drain();
   endtask

   task automatic test_bypass();
      do_reset();
      set_req0(1, 5'b01010, 32'h00FF0000, 32'h000000FF);
      settle(); advance();
      req0_valid = 0;
      settle(); advance();
      set_req0(1, 5'b01110, 32'd1, 32'd31);
      resp0_ready = 1;
      settle();
      checks++;
      if (resp0_valid !== 1'b1 || resp0_res !== 32'h00FF00FF || req0_ready !== 1'b1) begin
         errors++; $display("FAIL bypass_accept got=%b/%h/%b exp=1/00ff00ff/1", resp0_valid, resp0_res, req0_ready);
      end
      advance();
      req0_valid = 0; resp0_ready = 0;
      settle();
      checks++;
      if (resp0_valid !== 1'b0) begin errors++; $display("FAIL bypass_gap got=%b exp=0", resp0_valid); end
      advance();
      settle();
      checks++;
      if (resp0_valid !== 1'b1 || resp0_res !== 32'h80000000) begin
         errors++; $display("FAIL bypass_result got=%b/%h exp=1/80000000", resp0_valid, resp0_res);
      end
      advance();
      drain();
   endtask

   task automatic test_undef_op();
      set_req1(1, 5'b11111, $urandom, $urandom);
      settle();
      checks++;
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL undef_accept got=%b exp=1", req1_ready); end
      advance();
      req1_valid = 0;
      settle(); advance();
      resp1_ready = 1;
      settle();
      checks++;
      if (resp1_valid !== 1'b1 || resp1_res !== 32'd0) begin
         errors++; $display("FAIL undef_result got=%b/%h exp=1/00000000", resp1_valid, resp1_res);
      end
      advance();
      resp1_ready = 0;
      settle();
      checks++;
      if (resp1_valid !== 1'b0) begin errors++; $display("FAIL undef_pop got=%b exp=0", resp1_valid); end
      advance();
      drain();
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [4:0] ops [13];
      ops = '{5'd0, 5'd2, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd31};
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         set_req0($urandom_range(0, 9) < 6, ops[$urandom_range(0, 12)], rnd32(), rnd32());
         set_req1($urandom_range(0, 9) < 6, ops[$urandom_range(0, 12)], rnd32(), rnd32());
         resp0_ready = $urandom_range(0, 9) < 6;
         resp1_ready = $urandom_range(0, 9) < 6;
         settle();
         checks++;
         if ({req1_ready, req0_ready} !== e_rdy) begin
            errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {req1_ready, req0_ready}, e_rdy);
         end
         checks++;
         if ({resp1_valid, resp0_valid} !== e_rv) begin
            errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, {resp1_valid, resp0_valid}, e_rv);
         end
         if (e_rv[0]) begin
            checks++;
            if (resp0_res !== m_res[0]) begin errors++; $display("FAIL rnd_res0 cyc=%0d got=%h exp=%h", cyc, resp0_res, m_res[0]); end
         end
         if (e_rv[1]) begin
            checks++;
            if (resp1_res !== m_res[1]) begin errors++; $display("FAIL rnd_res1 cyc=%0d got=%h exp=%h", cyc, resp1_res, m_res[1]); end
         end
         checks++;
         if ({alu_src0, alu_src1, alu_op} !== {m_a0, m_a1, m_aop}) begin
            errors++; $display("FAIL rnd_alu cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, alu_src0, alu_src1, alu_op, m_a0, m_a1, m_aop);
         end
         advance();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_tie();
      test_backpressure();
      test_bypass();
      test_undef_op();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
